uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DIV_BASE, default 10416, clocks per bit at baud_sel=00 (9600 baud at 100 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data  input  8  byte to transmit; sampled when valid && ready.
REQ-005 valid  input  1  upstream asserts when data is meaningful.
REQ-006 ready  output  1  high when the holding register is empty and a byte can be accepted.
REQ-007 baud_sel  input  2  rate select: 00 -> DIV_BASE, 01 -> DIV_BASE/2, 10 -> DIV_BASE/4, 11 -> DIV_BASE/12 (868 clocks, 115200).
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is on the line (start through end of stop bit).

Function
REQ-010 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly N clocks, N per REQ-007.
REQ-011 Handshake SHALL transfer a byte on any rising edge with valid=1 and ready=1; valid without ready SHALL have no effect, and data may change freely while ready=0.
REQ-012 Block SHALL contain one 8-bit holding register plus one shift register; ready = holding register empty.
REQ-013 States SHALL be IDLE, START, DATA, STOP; IDLE -> START when the holding register is full; START -> DATA after N clocks; DATA -> STOP after 8 bit periods; STOP -> START if the holding register is full at the end of the stop bit, else IDLE.
REQ-014 On IDLE -> START or STOP -> START, the holding register SHALL move into the shift register and be marked empty in the same cycle, so ready rises one cycle later.
REQ-015 tx SHALL go low on the first clock after the transition into START; latency from the accepting edge to tx falling SHALL be 2 clocks when idle.
REQ-016 Back-to-back frames SHALL have zero idle clocks between the stop bit and the next start bit.
REQ-017 baud_sel SHALL be latched at frame start; changes mid-frame SHALL affect only the next frame.
REQ-018 Bit counter SHALL count 0..N-1 and bit index 0..7 with no wrap beyond 7; the bit counter width SHALL hold DIV_BASE-1.
REQ-019 A new byte accepted while a frame is in progress SHALL not disturb the current frame.
REQ-020 busy SHALL be 0 in IDLE and 1 in START/DATA/STOP; tx SHALL be registered (glitch-free).

Reset
REQ-021 On rst=1 at a clock edge: state=IDLE, tx=1, busy=0, ready=1, holding register empty, counters 0.
REQ-022 Reset mid-frame SHALL abort the frame immediately (tx=1 on the following cycle) and discard any held byte.
REQ-023 rst SHALL take priority over a simultaneous valid && ready transfer; the byte is dropped.

Verification
REQ-024 Idle, baud_sel=00, send 0x63 -> tx falls 2 clocks after accept; line = 0,1,1,0,0,0,1,1,0,1, each 10416 clocks; busy high 104160 clocks.
REQ-025 Send 0x8E then 0x55 back-to-back with valid held -> second accept occurs 1 cycle after the first frame starts; stop bit of 0x8E is followed directly by the start bit of 0x55, with no idle clocks.
REQ-026 baud_sel=11, send 0xA5 -> each bit 868 clocks; toggle baud_sel to 00 mid-frame -> bit length unchanged until the frame ends.
REQ-027 Assert rst during data bit 4 with a byte held -> tx=1, busy=0, ready=1 next cycle; no further frame is sent.
REQ-028 valid=1 while ready=0 with changing data -> only the values present on accepting edges are transmitted, in order.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register and a
// run-time selectable bit rate.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   data     in   [7:0] byte to send, captured when valid && ready
//   valid    in   upstream has a byte
//   ready    out  holding register empty
//   baud_sel in   [1:0] 00:DIV_BASE 01:/2 10:/4 11:/12 clocks per bit
//   tx       out  registered serial line, idle high
//   busy     out  frame on the line (start through stop bit)

module uart_tx #(
  parameter int unsigned DIV_BASE = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic [1:0] baud_sel,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(DIV_BASE + 1);

  localparam logic [CntW-1:0] Lim0 = CntW'(DIV_BASE - 1);
  localparam logic [CntW-1:0] Lim1 = CntW'(DIV_BASE / 2 - 1);
  localparam logic [CntW-1:0] Lim2 = CntW'(DIV_BASE / 4 - 1);
  localparam logic [CntW-1:0] Lim3 = CntW'(DIV_BASE / 12 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      shift_q, shift_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] lim_q, lim_d;
  logic [2:0]      idx_q, idx_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  logic            bit_end;
  logic            load;

  assign bit_end = (cnt_q == lim_q);
  assign ready   = ~hold_full_q;
  assign tx      = tx_q;
  assign busy    = busy_q;

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      cnt_q       <= '0;
      lim_q       <= '0;
      idx_q       <= 3'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic. load marks the cycle a held byte moves into the
  // shift register, which also starts a new frame.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          state_d = StStart;
          load    = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && (idx_q == 3'd7)) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (hold_full_q) begin
            state_d = StStart;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: holding register, shift register, counters and
  // the per-frame bit length.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    idx_d       = idx_q;

    // load and accept are mutually exclusive: load needs a full holding
    // register, accept needs an empty one.
    if (load) begin
      hold_full_d = 1'b0;
    end else if (valid && ready) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shift_d = hold_q;
      cnt_d   = '0;
      idx_d   = 3'd0;
      // Rate is frozen for the whole frame.
      unique case (baud_sel)
        2'b00:   lim_d = Lim0;
        2'b01:   lim_d = Lim1;
        2'b10:   lim_d = Lim2;
        default: lim_d = Lim3;
      endcase
    end else if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
      if ((state_q == StData) && bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
      end
    end
  end

  // Output logic. tx and busy are registered, so the line trails the
  // state by one clock uniformly and every bit still lasts exactly N clocks.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != StIdle);
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Uses a reduced DIV_BASE so whole frames fit in
// a short run: N = 120 / 60 / 30 / 10 clocks per bit for baud_sel 00..11.

module tb_uart_tx;

  localparam int unsigned Div = 120;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [1:0] baud_sel;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_tx #(
    .DIV_BASE(Div)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .baud_sel (baud_sel),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered on the first clock of the start bit (tx already low). Checks
  // first and last clock of each of the 10 bits and the busy length. Leaves
  // the caller on the last clock of the stop bit.
  // tog_at >= 0 changes baud_sel at that clock; jam drives valid with
  // changing data whenever ready is low.
  task automatic frame(input logic [7:0] b, input int n, input int tog_at,
                       input logic [1:0] tog_sel, input bit jam, input string tag);
    int   busy_cnt;
    logic e;
    busy_cnt = 0;
    for (int i = 0; i < 10 * n; i++) begin
      int bi;
      bi = i / n;
      if (bi == 0)      e = 1'b0;
      else if (bi == 9) e = 1'b1;
      else              e = b[bi-1];
      if ((i % n) == 0)     chk($sformatf("%s_bit%0d_first", tag, bi), {31'd0, tx}, {31'd0, e});
      if ((i % n) == n - 1) chk($sformatf("%s_bit%0d_last", tag, bi), {31'd0, tx}, {31'd0, e});
      if (busy === 1'b1) busy_cnt++;
      if (i == tog_at) baud_sel = tog_sel;
      if (jam) begin
        valid = ~ready;
        data  = data + 8'h3B;
      end
      if (i < 10 * n - 1) tick();
    end
    chk({tag, "_busy_len"}, busy_cnt, 10 * n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},    {31'd0, tx},    32'd1);
    chk({tag, "_busy"},  {31'd0, busy},  32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int bad;
    rst      = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;
    baud_sel = 2'b00;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // Single frame at N=120, 0x63.
    data  = 8'h63;
    valid = 1'b1;
    tick();                                   // accepted
    valid = 1'b0;
    chk("f63_ready_low", {31'd0, ready}, 32'd0);
    chk("f63_tx_idle1",  {31'd0, tx},    32'd1);
    tick();
    chk("f63_ready_rise", {31'd0, ready}, 32'd1);
    chk("f63_tx_idle2",   {31'd0, tx},    32'd1);
    tick();
    chk("f63_latency2", {31'd0, tx}, 32'd0);
    frame(8'h63, Div, -1, 2'b00, 1'b0, "f63");
    tick();
    chk_idle("f63_after");

    // Back-to-back at N=60, valid held: 0x8E then 0x55.
    baud_sel = 2'b01;
    data     = 8'h8E;
    valid    = 1'b1;
    tick();                                   // 0x8E accepted
    chk("b2b_ready_low", {31'd0, ready}, 32'd0);
    data = 8'h55;
    tick();                                   // frame starts
    chk("b2b_ready_rise", {31'd0, ready}, 32'd1);
    tick();                                   // 0x55 accepted
    valid = 1'b0;
    chk("b2b_second_held", {31'd0, ready}, 32'd0);
    chk("b2b_start_low",   {31'd0, tx},    32'd0);
    frame(8'h8E, Div / 2, -1, 2'b00, 1'b0, "f8e");
    tick();
    frame(8'h55, Div / 2, -1, 2'b00, 1'b0, "f55");
    tick();
    chk_idle("b2b_after");

    // N=10 frame; switching baud_sel mid-frame must not change it.
    baud_sel = 2'b11;
    data     = 8'hA5;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    chk("fa5_start_low", {31'd0, tx}, 32'd0);
    frame(8'hA5, Div / 12, 25, 2'b00, 1'b0, "fa5");
    tick();
    chk_idle("fa5_after");

    // Next frames pick up baud_sel=00 (N=120); valid jammed with changing
    // data while ready is low must never be accepted.
    data  = 8'h3C;
    valid = 1'b1;
    tick();
    data = 8'hC3;
    tick();
    chk("jam_ready_rise", {31'd0, ready}, 32'd1);
    tick();
    valid = 1'b0;
    chk("jam_start_low", {31'd0, tx}, 32'd0);
    frame(8'h3C, Div, -1, 2'b00, 1'b1, "f3c");
    tick();
    frame(8'hC3, Div, -1, 2'b00, 1'b1, "fc3");
    valid = 1'b0;
    tick();
    repeat (5) tick();
    chk_idle("jam_after");

    // Reset during data bit 4 with a byte held.
    baud_sel = 2'b11;
    data     = 8'h0F;
    valid    = 1'b1;
    tick();
    data = 8'h99;
    tick();
    tick();
    valid = 1'b0;
    chk("rstmid_held",  {31'd0, ready}, 32'd0);
    chk("rstmid_start", {31'd0, tx},    32'd0);
    repeat (55) tick();                       // middle of data bit 4
    chk("rstmid_bit4_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rstmid_next");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rstmid_no_frame", bad, 0);

    // Reset wins over a simultaneous transfer.
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h77;
    tick();
    rst   = 1'b0;
    valid = 1'b0;
    chk("rstpri_ready", {31'd0, ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rstpri_no_frame", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
